// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_DRAIN = 2'd2
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int unsigned PC_STEP_DEFAULT  = 4;

  // Byte-offset bits cleared from a redirect target (word-aligned fetch).
  localparam logic [1:0] PC_ALIGN_LOW = 2'b11;

endpackage

// File: rtl/Add.sv
// Combinational adder shared across the datapath.
module Add #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] digit1,
  input  logic [WIDTH-1:0] digit2,
  output logic [WIDTH-1:0] result
);

  assign result = digit1 + digit2;

endmodule

// File: rtl/pc_fetch_stage.sv
// Instruction-fetch front end: owns the PC, issues one fetch at a time, feeds IF/ID.
// Optional performance counters are enabled with `define FETCH_PERF_CNT_EN.
//
// state   | meaning
// S_REQ   | no fetch outstanding; request issued when IF/ID has room
// S_WAIT  | fetch outstanding, response will be delivered
// S_DRAIN | fetch outstanding but squashed by a redirect, response dropped
module pc_fetch_stage
  import fetch_pkg::*;
#(
  parameter int                XLEN     = 32,
  parameter logic [XLEN-1:0]   RESET_PC = XLEN'(RESET_PC_DEFAULT),
  parameter int unsigned       PC_STEP  = PC_STEP_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            stall,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_pc_plus4,
  output logic [XLEN-1:0] if_instr
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_squashed
`endif
);

  fetch_state_t    state, state_nxt;
  logic [XLEN-1:0] pc, pc_next_seq, target_aligned;
  logic            req, load_bundle;

  Add #(.WIDTH(XLEN)) u_add (
    .digit1 (pc),
    .digit2 (XLEN'(PC_STEP)),
    .result (pc_next_seq)
  );

  assign target_aligned = redirect_target & ~XLEN'(PC_ALIGN_LOW);
  assign imem_addr      = pc;
  assign imem_req_valid = req;

  always_comb begin
    req         = 1'b0;
    load_bundle = 1'b0;
    state_nxt   = state;
    case (state)
      S_REQ: begin
        req = !reset && !redirect_valid && (!if_valid || !stall);
        if (req && imem_req_ready) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          state_nxt   = S_REQ;
          load_bundle = !redirect_valid;
        end else if (redirect_valid) begin
          state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (imem_rsp_valid) state_nxt = S_REQ;
      end
      default: state_nxt = S_REQ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_REQ;
      pc    <= RESET_PC;
    end else begin
      state <= state_nxt;
      if (redirect_valid)   pc <= target_aligned;
      else if (load_bundle) pc <= pc_next_seq;
    end
  end

  // Redirect flushes IF/ID even when the bundle would otherwise be held by stall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      if_valid    <= 1'b0;
      if_pc       <= '0;
      if_pc_plus4 <= '0;
      if_instr    <= '0;
    end else if (redirect_valid) begin
      if_valid <= 1'b0;
    end else if (load_bundle) begin
      if_valid    <= 1'b1;
      if_pc       <= pc;
      if_pc_plus4 <= pc_next_seq;
      if_instr    <= imem_rsp_data;
    end else if (if_valid && !stall) begin
      if_valid <= 1'b0;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic rsp_drop;

  assign rsp_drop = imem_rsp_valid &&
                    ((state == S_DRAIN) || ((state == S_WAIT) && redirect_valid));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetched  <= '0;
      perf_squashed <= '0;
    end else begin
      if (load_bundle && (perf_fetched != 32'hFFFF_FFFF))
        perf_fetched <= perf_fetched + 32'd1;
      if (rsp_drop && (perf_squashed != 32'hFFFF_FFFF))
        perf_squashed <= perf_squashed + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Self-checking bench for pc_fetch_stage: transaction-level memory/pipeline model,
// directed redirect vectors, stall/reset sequences and randomized traffic.
module tb_pc_fetch_stage;

  localparam logic [31:0] KEY    = 32'hA5A5_A5A5;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        stall = 1'b0;
  logic        if_valid;
  logic [31:0] if_pc, if_pc_plus4, if_instr;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_squashed;
`endif

  pc_fetch_stage dut (
    .clk             (clk),
    .reset           (reset),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_addr       (imem_addr),
    .imem_rsp_valid  (imem_rsp_valid),
    .imem_rsp_data   (imem_rsp_data),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .stall           (stall),
    .if_valid        (if_valid),
    .if_pc           (if_pc),
    .if_pc_plus4     (if_pc_plus4),
    .if_instr        (if_instr)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched    (perf_fetched),
    .perf_squashed   (perf_squashed)
`endif
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Reference model: outstanding fetches, expected IF/ID bundle, next fetch address.
  logic [31:0] q_addr[$];
  int          q_due[$];
  int          cyc = 0;
  int          lat_min = 1, lat_max = 1;
  logic        bvalid = 1'b0;
  logic [31:0] bpc = '0;
  logic [31:0] nxt = RST_PC;
  logic        squash = 1'b0;
  int          n_fetched = 0, n_squashed = 0, n_deliv_total = 0;

  typedef struct {
    logic [31:0] target;
    logic        same_cycle;
    logic [31:0] exp_pc;
    logic [31:0] exp_next;
  } redir_vec_t;

  redir_vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // One clock cycle: drive inputs, compare outputs against the model, advance the model.
  task automatic step(input logic st, input logic rd, input logic [31:0] tg, input logic rdy);
    logic        rsp, drop, exp_req, consume;
    logic [31:0] head;
    stall           = st;
    redirect_valid  = rd;
    redirect_target = tg;
    imem_req_ready  = rdy;
    rsp  = (q_addr.size() > 0) && (q_due[0] <= cyc);
    head = (q_addr.size() > 0) ? q_addr[0] : 32'h0;
    imem_rsp_valid = rsp;
    imem_rsp_data  = rsp ? (head ^ KEY) : $urandom;
    #1;
    exp_req = (q_addr.size() == 0) && !rd && (!bvalid || !st);
    check("if_valid", {31'b0, if_valid}, {31'b0, bvalid});
    if (bvalid) begin
      check("if_pc", if_pc, bpc);
      check("if_pc_plus4", if_pc_plus4, bpc + 32'd4);
      check("if_instr", if_instr, bpc ^ KEY);
    end
    check("imem_req_valid", {31'b0, imem_req_valid}, {31'b0, exp_req});
    if (exp_req) check("imem_addr", imem_addr, nxt);
`ifdef FETCH_PERF_CNT_EN
    check("perf_fetched", perf_fetched, n_fetched);
    check("perf_squashed", perf_squashed, n_squashed);
`endif
    drop    = squash || rd;
    consume = bvalid && !st;
    if (rsp) begin
      void'(q_addr.pop_front());
      void'(q_due.pop_front());
      if (drop) n_squashed++;
      else begin
        n_fetched++;
        n_deliv_total++;
      end
      squash = 1'b0;
    end else if (rd && (q_addr.size() > 0)) begin
      squash = 1'b1;
    end
    if (rd) bvalid = 1'b0;
    else if (rsp && !drop) begin
      bvalid = 1'b1;
      bpc    = head;
    end else if (consume) bvalid = 1'b0;
    if (exp_req && rdy) begin
      q_addr.push_back(nxt);
      q_due.push_back(cyc + int'($urandom_range(lat_max, lat_min)));
    end
    if (rd) nxt = tg & 32'hFFFF_FFFC;
    else if (rsp && !drop) nxt = head + 32'd4;
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  // Asynchronous reset between edges; memory side is reset along with the DUT.
  task automatic do_reset();
    #2;
    reset          = 1'b1;
    imem_req_ready = 1'b0;
    #1;
    check("rst_if_valid", {31'b0, if_valid}, 32'd0);
    check("rst_if_pc", if_pc, 32'd0);
    check("rst_if_pc_plus4", if_pc_plus4, 32'd0);
    check("rst_if_instr", if_instr, 32'd0);
    check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    q_addr.delete();
    q_due.delete();
    bvalid = 1'b0;
    nxt    = RST_PC;
    squash = 1'b0;
    n_fetched  = 0;
    n_squashed = 0;
    imem_rsp_valid = 1'b0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!if_valid && n < 30) begin
      step(1'b0, 1'b0, 32'h0, 1'b1);
      n++;
    end
    check(name, {31'b0, if_valid}, 32'd1);
  endtask

  initial begin
    vecs[0] = '{32'h0000_1002, 1'b0, 32'h0000_1000, 32'h0000_1004};
    vecs[1] = '{32'h0000_2000, 1'b1, 32'h0000_2000, 32'h0000_2004};
    vecs[2] = '{32'hFFFF_FFFC, 1'b0, 32'hFFFF_FFFC, 32'h0000_0000};
    vecs[3] = '{32'h8000_0003, 1'b1, 32'h8000_0000, 32'h8000_0004};
    vecs[4] = '{32'h0000_0007, 1'b0, 32'h0000_0004, 32'h0000_0008};

    do_reset();

    // Sequential fetch, 1-cycle memory: one instruction every other cycle.
    lat_min = 1;
    lat_max = 1;
    step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check("first_valid", {31'b0, if_valid}, 32'd1);
    check("first_pc", if_pc, RST_PC);
    for (int k = 1; k <= 3; k++) begin
      step(1'b0, 1'b0, 32'h0, 1'b1);
      step(1'b0, 1'b0, 32'h0, 1'b1);
      check("seq_pc", if_pc, 32'(4 * k));
      check("seq_instr", if_instr, 32'(4 * k) ^ KEY);
    end

    // Stall holds the bundle and blocks new requests; release requests at once.
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 1'b0, 32'h0, 1'b1);
      check("stall_pc", if_pc, 32'd12);
      check("stall_no_req", {31'b0, imem_req_valid}, 32'd0);
    end
    stall = 1'b0;
    #1;
    check("release_req", {31'b0, imem_req_valid}, 32'd1);
    check("release_addr", imem_addr, 32'd16);
    step(1'b0, 1'b0, 32'h0, 1'b1);

    // Redirect vectors, in S_WAIT or coinciding with the response.
    lat_min = 3;
    lat_max = 3;
    foreach (vecs[v]) begin
      int n = 0;
      while (!((q_addr.size() > 0) &&
               (vecs[v].same_cycle ? (q_due[0] <= cyc) : (q_due[0] > cyc))) && n < 30) begin
        step(1'b0, 1'b0, 32'h0, 1'b1);
        n++;
      end
      check("redir_setup", {31'b0, (n < 30)}, 32'd1);
      step(1'b0, 1'b1, vecs[v].target, 1'b1);
      check("redir_flush", {31'b0, if_valid}, 32'd0);
      wait_valid("redir_wait");
      check("redir_pc", if_pc, vecs[v].exp_pc);
      check("redir_plus4", if_pc_plus4, vecs[v].exp_pc + 32'd4);
      check("redir_instr", if_instr, vecs[v].exp_pc ^ KEY);
      step(1'b0, 1'b0, 32'h0, 1'b1);
      wait_valid("redir_wait_next");
      check("redir_next_pc", if_pc, vecs[v].exp_next);
    end

    // Reset in S_WAIT with the memory not ready, then with a held bundle.
    begin
      int n = 0;
      while (q_addr.size() == 0 && n < 10) begin
        step(1'b0, 1'b0, 32'h0, 1'b1);
        n++;
      end
    end
    do_reset();
    step(1'b0, 1'b0, 32'h0, 1'b1);
    wait_valid("post_rst_valid");
    check("post_rst_pc", if_pc, RST_PC);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    check("held_before_rst", {31'b0, if_valid}, 32'd1);
    do_reset();

    // Randomized traffic with variable memory latency and a mid-run reset.
    lat_min = 1;
    lat_max = 4;
    n_deliv_total = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      step(($urandom % 100) < 30, ($urandom % 100) < 5, $urandom, ($urandom % 100) < 70);
    end
    check("random_progress", {31'b0, (n_deliv_total > 100)}, 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pc_fetch_stage.md
Name: pc_fetch_stage

Overview:
- Instruction-fetch front end of the pipeline.
- Owns the program counter and issues one fetch at a time to instruction memory using a valid/ready request and an in-order response.
- Computes pc+4 through the existing `Add` block.
- Presents {pc, pc_plus4, instr} to the IF/ID register with valid/stall flow control, and handles branch/jump redirects that squash an in-flight fetch.

Parameters:
- XLEN, 32, datapath and address width.
- RESET_PC, 32'h00000000, PC value loaded on reset.
- PC_STEP, 4, sequential increment fed to `Add`.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts request.
- imem_addr  output  XLEN  fetch address; equals pc.
- imem_rsp_valid  input  1  fetch response valid; exactly one per accepted request, at least 1 cycle after acceptance.
- imem_rsp_data  input  XLEN  fetched instruction word.
- redirect_valid  input  1  branch/jump taken, single-cycle pulse.
- redirect_target  input  XLEN  new PC.
- stall  input  1  IF/ID cannot accept this cycle.
- if_valid  output  1  output bundle valid.
- if_pc  output  XLEN  PC of the fetched instruction.
- if_pc_plus4  output  XLEN  if_pc + PC_STEP.
- if_instr  output  XLEN  fetched instruction.

Behaviour:
- Reset (asynchronous, active-high):
  - pc = RESET_PC, state = S_REQ.
  - if_valid = 0; if_pc, if_pc_plus4 and if_instr = 0.
  - imem_req_valid = 0 while reset is asserted.
- Output handshake:
  - The bundle is consumed on any clk edge where if_valid=1 and stall=0.
  - Output registers hold while if_valid=1 and stall=1.
- States:
  - S_REQ: imem_req_valid = !redirect_valid && (!if_valid || !stall).
    - Request accepted (valid & ready) -> S_WAIT.
    - Otherwise stay in S_REQ.
  - S_WAIT: imem_req_valid = 0.
    - Invariant: the output register is empty.
    - On rsp without redirect: load if_instr = rsp_data, if_pc = pc, if_pc_plus4 = pc+PC_STEP; set if_valid=1; pc <= pc+PC_STEP; go to S_REQ.
  - S_DRAIN: waits for a squashed response.
    - On rsp: drop the data, if_valid stays 0, go to S_REQ.
- Redirect (priority over stall and rsp, in every state):
  - pc <= {redirect_target[XLEN-1:2], 2'b00}.
  - if_valid <= 0 (flush the IF/ID bundle).
  - S_REQ -> S_REQ with no request that cycle.
  - S_WAIT -> S_DRAIN.
  - S_WAIT with rsp in the same cycle: the response is dropped, go to S_REQ.
  - S_DRAIN -> S_DRAIN; with rsp in the same cycle -> S_REQ.
- Arithmetic: pc+PC_STEP wraps modulo 2^XLEN (32'hFFFFFFFC -> 32'h00000000).
- Throughput: with a 1-cycle memory and no stall, one instruction every 2 cycles. The first if_valid appears 2 cycles after reset release.
- Reset mid-operation: the outstanding response is not tracked; the memory side is reset by the same reset.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined: adds output ports perf_fetched [31:0] and perf_squashed [31:0].
  - perf_fetched counts delivered instructions (if_valid loads).
  - perf_squashed counts responses dropped in S_DRAIN or on same-cycle redirect.
  - Both counters are reset to 0 and saturate at 32'hFFFFFFFF.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- fetch_pkg holds:
  - the state enum {S_REQ, S_WAIT, S_DRAIN} (2-bit encoding);
  - constants RESET_PC_DEFAULT and PC_STEP_DEFAULT;
  - the alignment mask.
- Sub-module: instantiate the existing `Add` (digit1 = pc, digit2 = PC_STEP, result = pc_next_seq). No new sub-module.

Test Plan:
- Reset release, memory ready=1 with 1-cycle latency, instr = addr^32'hA5A5A5A5:
  - if_pc sequence 0, 4, 8, 12 on alternate cycles;
  - if_pc_plus4 = if_pc+4;
  - instr matches.
- Stall held 5 cycles while if_valid=1 -> outputs frozen and no new imem_req_valid. Stall released -> the next request issues the same cycle.
- Redirect to 32'h00001002 in S_WAIT:
  - the next response is dropped and perf_squashed = 1;
  - the next if_pc = 32'h00001000.
- Redirect and rsp in the same cycle -> no if_valid for that response; the fetch restarts at the target.
- pc = 32'hFFFFFFFC -> if_pc_plus4 = 32'h00000000; the next fetch address is 0.
- Async reset asserted mid-S_WAIT with imem_req_ready=0 -> if_valid drops immediately; after release the first request has address RESET_PC.
